chirp_sequencer: RTL and testbench

Controls a multi-pulse radar acquisition. It drives the chirp generator's `chirp_init` and `chirp_enable` inputs and the ADC capture gate `adc_enable`, and it fires a programmed number of chirps at a fixed pulse repetition interval (PRI). For each chirp it opens an ADC capture window with a programmed delay and length. It sits in the 100 MHz control domain, between the register/control bus and the FMC150 DAC/ADC datapath. The chirp status inputs come from the 245.76 MHz domain and are synchronized inside this block.

---
 rtl/chirp_seq_pkg.sv | 16 +
 rtl/adc_window_gen.sv | 54 +++++
 rtl/chirp_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_chirp_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chirp_seq_pkg.sv
// rtl/chirp_seq_pkg.sv - shared state encoding and parameter defaults for the chirp sequencer
package chirp_seq_pkg;

  localparam int DEF_CNT_WIDTH      = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    FIRE,
    ACTIVE,
    PRI_WAIT,
    FINISH
  } seq_state_e;

endpackage

// File: rtl/adc_window_gen.sv
// rtl/adc_window_gen.sv - per-pulse ADC capture gate driven by a saturating window counter
module adc_window_gen #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 restart_i,
  input  logic                 clear_i,
  input  logic [CNT_WIDTH-1:0] delay_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  output logic                 adc_enable_o,
  output logic                 window_done_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 run_q, run_d;
  logic                 adc_q, adc_d;
  logic [CNT_WIDTH:0]   win_end;
  logic [CNT_WIDTH:0]   cnt_ext;

  // One extra bit so delay+len can never wrap back into the window.
  assign win_end = {1'b0, delay_i} + {1'b0, len_i};
  assign cnt_ext = {1'b0, cnt_q};

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (clear_i) begin
      run_d = 1'b0;
    end else if (restart_i) begin
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    adc_d = run_q && !clear_i && (cnt_q >= delay_i) && (cnt_ext < win_end);
  end

  assign window_done_o = !run_q || (len_i == '0) || (cnt_ext >= win_end);
  assign adc_enable_o  = adc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      adc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      adc_q <= adc_d;
    end
  end

endmodule

// File: rtl/chirp_sequencer.sv
// rtl/chirp_sequencer.sv - multi-pulse radar acquisition sequencer (chirp handshake, PRI, ADC gate)
module chirp_sequencer
  import chirp_seq_pkg::*;
#(
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk_100Mhz,
  input  logic                 clk_100Mhz_rst,
  input  logic                 seq_start,
  input  logic                 seq_abort,
  input  logic [CNT_WIDTH-1:0] cfg_num_pulses,
  input  logic [CNT_WIDTH-1:0] cfg_adc_delay,
  input  logic [CNT_WIDTH-1:0] cfg_capture_len,
  input  logic [CNT_WIDTH-1:0] cfg_pri,
  input  logic                 chirp_ready,
  input  logic                 chirp_active,
  output logic                 chirp_init,
  output logic                 chirp_enable,
  output logic                 adc_enable,
  output logic                 seq_busy,
  output logic                 seq_done,
  output logic                 seq_error,
  output logic [CNT_WIDTH-1:0] pulse_count
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  seq_state_e           state_q, state_d;
  logic                 ready_meta_q, ready_s_q;
  logic                 active_meta_q, active_s_q, active_prev_q;
  logic                 start_prev_q;
  logic [CNT_WIDTH-1:0] num_q, num_d, delay_q, delay_d, len_q, len_d, pri_q, pri_d;
  logic [CNT_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d, new_count;
  logic [CNT_WIDTH-1:0] pri_cnt_q, pri_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 err_q, err_d, done_q, done_d;
  logic                 init_q, init_d, enable_q, enable_d, busy_q, busy_d;
  logic                 start_edge, active_fall, to_expired, pri_reached;
  logic                 fire_entry, win_clear, win_done;

  assign start_edge  = seq_start & ~start_prev_q;
  assign active_fall = active_prev_q & ~active_s_q;
  assign to_expired  = (to_cnt_q == TO_LAST);
  assign pri_reached = ({1'b0, pri_cnt_q} + (CNT_WIDTH+1)'(1)) >= {1'b0, pri_q};
  assign new_count   = pulse_cnt_q + CNT_WIDTH'(1);
  assign fire_entry  = (state_d == FIRE) && (state_q != FIRE);
  assign win_clear   = (state_d == IDLE);

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    delay_d     = delay_q;
    len_d       = len_q;
    pri_d       = pri_q;
    pulse_cnt_d = pulse_cnt_q;
    err_d       = err_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d     = INIT;
          pulse_cnt_d = '0;
          err_d       = 1'b0;
          num_d       = cfg_num_pulses;
          delay_d     = cfg_adc_delay;
          len_d       = cfg_capture_len;
          pri_d       = cfg_pri;
        end
      end
      INIT: begin
        if (ready_s_q) begin
          state_d = FIRE;
        end else if (to_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      FIRE: begin
        if (active_s_q) begin
          state_d = ACTIVE;
        end else if (to_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      ACTIVE: begin
        if (active_fall) begin
          pulse_cnt_d = new_count;
          state_d     = ((num_q != '0) && (new_count == num_q)) ? FINISH : PRI_WAIT;
        end else if (to_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      PRI_WAIT: begin
        if (pri_reached && win_done && ready_s_q) state_d = FIRE;
      end
      FINISH: begin
        if (win_done) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything decided above, including a same-cycle start.
    if (seq_abort) begin
      state_d     = IDLE;
      num_d       = num_q;
      delay_d     = delay_q;
      len_d       = len_q;
      pri_d       = pri_q;
      pulse_cnt_d = pulse_cnt_q;
      err_d       = err_q;
      done_d      = 1'b0;
    end
  end

  always_comb begin
    pri_cnt_d = pri_cnt_q;
    if (fire_entry) pri_cnt_d = '0;
    else if (pri_cnt_q != '1) pri_cnt_d = pri_cnt_q + CNT_WIDTH'(1);

    to_cnt_d = to_cnt_q + TO_W'(1);
    if ((state_d != state_q) || !(state_q inside {INIT, FIRE, ACTIVE})) to_cnt_d = '0;

    init_d   = (state_q == INIT) && !seq_abort;
    enable_d = (state_q == FIRE) && !seq_abort;
    busy_d   = (state_q != IDLE) && !seq_abort;
  end

  adc_window_gen #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_window (
    .clk_i        (clk_100Mhz),
    .rst_i        (clk_100Mhz_rst),
    .restart_i    (fire_entry),
    .clear_i      (win_clear),
    .delay_i      (delay_q),
    .len_i        (len_q),
    .adc_enable_o (adc_enable),
    .window_done_o(win_done)
  );

  always_ff @(posedge clk_100Mhz or posedge clk_100Mhz_rst) begin
    if (clk_100Mhz_rst) begin
      ready_meta_q  <= 1'b0;
      ready_s_q     <= 1'b0;
      active_meta_q <= 1'b0;
      active_s_q    <= 1'b0;
      active_prev_q <= 1'b0;
      start_prev_q  <= 1'b0;
      state_q       <= IDLE;
      num_q         <= '0;
      delay_q       <= '0;
      len_q         <= '0;
      pri_q         <= '0;
      pulse_cnt_q   <= '0;
      pri_cnt_q     <= '0;
      to_cnt_q      <= '0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
      init_q        <= 1'b0;
      enable_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      ready_meta_q  <= chirp_ready;
      ready_s_q     <= ready_meta_q;
      active_meta_q <= chirp_active;
      active_s_q    <= active_meta_q;
      active_prev_q <= active_s_q;
      start_prev_q  <= seq_start;
      state_q       <= state_d;
      num_q         <= num_d;
      delay_q       <= delay_d;
      len_q         <= len_d;
      pri_q         <= pri_d;
      pulse_cnt_q   <= pulse_cnt_d;
      pri_cnt_q     <= pri_cnt_d;
      to_cnt_q      <= to_cnt_d;
      err_q         <= err_d;
      done_q        <= done_d;
      init_q        <= init_d;
      enable_q      <= enable_d;
      busy_q        <= busy_d;
    end
  end

  assign chirp_init   = init_q;
  assign chirp_enable = enable_q;
  assign seq_busy     = busy_q;
  assign seq_done     = done_q;
  assign seq_error    = err_q;
  assign pulse_count  = pulse_cnt_q;

endmodule

// File: tb/tb_chirp_sequencer.sv
// tb/tb_chirp_sequencer.sv - scoreboard bench for chirp_sequencer with a behavioural chirp generator
module tb_chirp_sequencer;

  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          seq_start, seq_abort;
  logic [CW-1:0] cfg_num, cfg_delay, cfg_len, cfg_pri;
  logic          chirp_ready, chirp_active;
  logic          chirp_init, chirp_enable, adc_enable, seq_busy, seq_done, seq_error;
  logic [CW-1:0] pulse_count;

  chirp_sequencer #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(1000)) dut (
    .clk_100Mhz     (clk),
    .clk_100Mhz_rst (rst),
    .seq_start      (seq_start),
    .seq_abort      (seq_abort),
    .cfg_num_pulses (cfg_num),
    .cfg_adc_delay  (cfg_delay),
    .cfg_capture_len(cfg_len),
    .cfg_pri        (cfg_pri),
    .chirp_ready    (chirp_ready),
    .chirp_active   (chirp_active),
    .chirp_init     (chirp_init),
    .chirp_enable   (chirp_enable),
    .adc_enable     (adc_enable),
    .seq_busy       (seq_busy),
    .seq_done       (seq_done),
    .seq_error      (seq_error),
    .pulse_count    (pulse_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int offset;
    int len;
    int pri;
    bit exact;
  } exp_t;

  exp_t   sb[$];
  exp_t   e;
  int     checks = 0;
  int     errors = 0;
  bit     mon_en = 1'b0;
  bit     gen_hold_ready = 1'b0;
  int     done_total = 0;
  longint cyc = 0, ce_rise = 0, adc_rise = 0, spacing = 0;
  bit     m_ce_prev = 1'b0, m_adc_prev = 1'b0;
  int     rdy_cnt = 0, act_cnt = 0;
  bit     g_ci_prev = 1'b0, g_ce_prev = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Chirp generator: ready 5 cycles after init rises, active for 50 cycles after enable rises.
  initial begin
    chirp_ready  = 1'b0;
    chirp_active = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        chirp_ready  = 1'b0;
        chirp_active = 1'b0;
        rdy_cnt      = 0;
        act_cnt      = 0;
      end else begin
        if (chirp_init && !g_ci_prev) begin
          chirp_ready = 1'b0;
          rdy_cnt     = 5;
        end else if (rdy_cnt > 0) begin
          rdy_cnt--;
          if (rdy_cnt == 0) chirp_ready = 1'b1;
        end
        if (gen_hold_ready) chirp_ready = 1'b0;
        if (chirp_enable && !g_ce_prev) begin
          chirp_active = 1'b1;
          act_cnt      = 50;
        end else if (act_cnt > 0) begin
          act_cnt--;
          if (act_cnt == 0) chirp_active = 1'b0;
        end
      end
      g_ci_prev = chirp_init;
      g_ce_prev = chirp_enable;
    end
  end

  // Monitor: one scoreboard entry is retired per completed capture window.
  initial begin
    forever begin
      tick();
      cyc++;
      if (seq_done) done_total++;
      if (mon_en) begin
        if (chirp_enable && !m_ce_prev) begin
          check("overlap_active", chirp_active, 0);
          check("overlap_window", m_adc_prev, 0);
          spacing = cyc - ce_rise;
          ce_rise = cyc;
        end
        if (adc_enable && !m_adc_prev) adc_rise = cyc;
        if (!adc_enable && m_adc_prev) begin
          if (sb.size() == 0) begin
            check("unexpected_window", 1, 0);
          end else begin
            e = sb.pop_front();
            check("adc_offset", adc_rise - ce_rise, e.offset);
            check("adc_len", cyc - adc_rise, e.len);
            if (e.exact) check("pri_spacing", spacing, e.pri);
            else check("pri_spacing_min", (spacing >= e.pri) ? 1 : 0, 1);
          end
        end
      end
      m_ce_prev  = chirp_enable;
      m_adc_prev = adc_enable;
    end
  end

  task automatic start_seq(input logic [CW-1:0] n, input logic [CW-1:0] d,
                           input logic [CW-1:0] l, input logic [CW-1:0] p);
    @(negedge clk);
    cfg_num   = n;
    cfg_delay = d;
    cfg_len   = l;
    cfg_pri   = p;
    seq_start = 1'b1;
    tick();
    check("start_lat1_init", chirp_init, 0);
    check("start_err_clear", seq_error, 0);
    tick();
    check("start_lat2_init", chirp_init, 1);
    check("start_busy", seq_busy, 1);
    seq_start = 1'b0;
    cfg_num   = $urandom;
    cfg_delay = $urandom;
    cfg_len   = $urandom;
    cfg_pri   = $urandom;
  endtask

  task automatic run_seq(input int n, input int d, input int l, input int p, input bit exact);
    int d0;
    int w;
    for (int i = 0; i < n; i++)
      sb.push_back('{offset: d, len: l, pri: (i == 0) ? 0 : p, exact: exact && (i > 0)});
    mon_en = 1'b1;
    d0     = done_total;
    start_seq(n, d, l, p);
    w = 0;
    while (done_total == d0 && w < n * (p + 200) + 500) begin
      tick();
      w++;
    end
    check("done_seen", done_total - d0, 1);
    check("pulse_count", pulse_count, n);
    repeat (5) tick();
    check("single_done", done_total - d0, 1);
    check("no_error", seq_error, 0);
    check("idle_not_busy", seq_busy, 0);
    check("sb_drained", sb.size(), 0);
    mon_en = 1'b0;
    sb.delete();
  endtask

  initial begin
    int  n, w, d0;
    bit  adc_p, seen, init_seen;
    seq_start = 1'b0;
    seq_abort = 1'b0;
    cfg_num   = '0;
    cfg_delay = '0;
    cfg_len   = '0;
    cfg_pri   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {chirp_init, chirp_enable, adc_enable, seq_busy, seq_done, seq_error}, 0);
    check("reset_pulse_count", pulse_count, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) tick();
    check("idle_after_reset", seq_busy, 0);

    run_seq(3, 10, 40, 200, 1'b1);
    run_seq(3, 10, 40, 20, 1'b0);
    repeat (4)
      run_seq($urandom_range(1, 4), $urandom_range(0, 40), $urandom_range(1, 40),
              $urandom_range(100, 300), 1'b1);

    // Handshake timeout in INIT.
    gen_hold_ready = 1'b1;
    repeat (10) tick();
    d0 = done_total;
    start_seq(2, 10, 40, 200);
    n = 1;
    while (n < 1100) begin
      tick();
      if (chirp_init) n++;
      else break;
    end
    check("timeout_init_cycles", n, 1000);
    repeat (3) tick();
    check("timeout_error", seq_error, 1);
    check("timeout_idle", seq_busy, 0);
    check("timeout_no_done", done_total - d0, 0);
    gen_hold_ready = 1'b0;
    run_seq(2, 5, 20, 150, 1'b1);

    // Continuous run, aborted inside the second capture window.
    d0 = done_total;
    start_seq(0, 10, 40, 200);
    n = 0;
    w = 0;
    adc_p = 1'b0;
    while (n < 2 && w < 2000) begin
      tick();
      w++;
      if (adc_enable && !adc_p) n++;
      adc_p = adc_enable;
    end
    check("abort_second_window", n, 2);
    repeat (5) tick();
    @(negedge clk) seq_abort = 1'b1;
    tick();
    check("abort_outputs", {chirp_init, chirp_enable, adc_enable, seq_busy}, 0);
    check("abort_pulse_count", pulse_count, 1);
    @(negedge clk) seq_abort = 1'b0;
    repeat (5) tick();
    check("abort_no_done", done_total - d0, 0);
    check("abort_error_held", seq_error, 0);
    check("abort_count_held", pulse_count, 1);

    // Window near the top of the counter range, plus a start edge while busy.
    start_seq(1, 32'hFFFF_FFF0, 32'h20, 200);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (adc_enable) seen = 1'b1;
    end
    check("wrap_pulse_done", pulse_count, 1);
    @(negedge clk) seq_start = 1'b1;
    init_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (chirp_init) init_seen = 1'b1;
      if (adc_enable) seen = 1'b1;
      if (i == 3) seq_start = 1'b0;
    end
    check("busy_start_ignored", init_seen, 0);
    check("busy_start_count", pulse_count, 1);
    check("busy_still", seq_busy, 1);
    check("wrap_no_adc", seen, 0);
    @(negedge clk) seq_abort = 1'b1;
    tick();
    seq_abort = 1'b0;
    repeat (3) tick();
    check("wrap_abort_idle", seq_busy, 0);

    // Asynchronous reset in the middle of the second pulse's ACTIVE phase.
    start_seq(3, 10, 40, 200);
    w = 0;
    while (!(pulse_count == 1 && chirp_active) && w < 1000) begin
      tick();
      w++;
    end
    check("reset_reach_active", (w < 1000) ? 1 : 0, 1);
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {chirp_init, chirp_enable, adc_enable, seq_busy, seq_done, seq_error}, 0);
    check("async_reset_count", pulse_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) tick();
    check("post_reset_idle", seq_busy, 0);
    check("post_reset_count", pulse_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    checks++;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
